rsa_job_ctrl: RTL and testbench
===============================

// Module: rsa_job_ctrl
// PURPOSE
//  Upstream sequencer for the RSA Avalon engine: host (PCIe BAR) programs a job count and GO,
//  block kicks the engine's 8-bit flag slave (write 1), polls it until it reads 0, repeats.
//  Reports progress/done/timeout to host via 32-bit Avalon-MM slave; optional done interrupt.
//  Host stages operand words in DRAM beforehand; this block never touches DRAM.
// PARAMETERS
//  CNT_W      16  width of job counter / done counter (<=16)
//  TMO_W      24  width of per-job timeout counter (cycles)
//  POLL_GAP   16  idle cycles between consecutive flag polls (>=1)
// PORTS
//  clk                 in   1      system clock (same domain as RSA engine Avalon ports)
//  reset               in   1      synchronous, active-low reset
//  avs_h_address       in   2      host register word address
//  avs_h_read          in   1      host read strobe
//  avs_h_write         in   1      host write strobe
//  avs_h_writedata     in   32     host write data
//  avs_h_readdata      out  32     host read data, combinational from address, zero latency
//  avs_h_waitrequest   out  1      tied 0
//  avm_f_address       out  1      flag slave address, always 0
//  avm_f_read          out  1      flag read request
//  avm_f_write         out  1      flag write request
//  avm_f_writedata     out  8      flag write data (8'h01 on kick)
//  avm_f_readdata      in   8      flag read data, valid in cycle read accepted; bit0 = busy
//  avm_f_waitrequest   in   1      flag slave stall
//  irq                 out  1      level interrupt (see CONFIGURATION)
// BEHAVIOUR
//  Registers: 0 CTRL  [0]GO w1 self-clear, [1]ABORT w1 self-clear, [2]IRQ_EN rw
//             1 JOBS  [CNT_W-1:0] rw, jobs per batch
//             2 STAT  [0]BUSY ro, [1]DONE w1c, [2]TMO w1c, [31:16] done_cnt ro (zero-extended)
//             3 TMO   [TMO_W-1:0] rw, per-job timeout limit; 0 = timeout disabled
//  Reset: all regs 0, state IDLE, avm_f_read/write 0, writedata 0, irq 0, done_cnt 0.
//  FSM: IDLE -> KICK -> GAP -> POLL -> (GAP | NEXT) ; NEXT -> KICK | IDLE.
//   IDLE: GO write with JOBS!=0 -> KICK next cycle, BUSY=1, done_cnt<=0, tmo_cnt<=0.
//         GO with JOBS==0 -> stay IDLE, set DONE next cycle, done_cnt<=0.
//   KICK: avm_f_write=1, writedata=8'h01; held stable while waitrequest=1;
//         accepted (waitrequest=0) -> GAP, gap_cnt<=POLL_GAP-1.
//   GAP : count gap_cnt down; at 0 -> POLL.
//   POLL: avm_f_read=1 held while waitrequest=1; on accept sample readdata[0]:
//         1 -> GAP (reload gap); 0 -> NEXT.
//   NEXT: done_cnt+1 (single cycle); if done_cnt+1==JOBS -> IDLE, BUSY=0, DONE=1; else KICK.
//  Timeout: tmo_cnt resets on KICK accept, +1 each cycle in GAP/POLL; reaching TMO (!=0)
//   -> TMO=1, BUSY=0, IDLE; pending POLL read completes first if already issued.
//  ABORT while busy: finish in-flight master transfer (no dropped handshake), then IDLE,
//   BUSY=0, DONE not set, done_cnt frozen. ABORT in IDLE: no effect.
//  GO while BUSY ignored. JOBS/TMO writes while BUSY take effect on next batch only (latched at GO).
//  Sticky DONE/TMO: hardware set and host w1c in same cycle -> set wins.
//  Master never asserts read and write together; address always 0.
//  Reset mid-batch: all state to reset values next edge; master strobes drop regardless of waitrequest.
// CONFIGURATION
//  RSA_JOB_CTRL_IRQ_EN defined: irq = IRQ_EN & (DONE | TMO), registered (1-cycle lag from flag set).
//  Undefined: irq tied 0; CTRL[2] reads 0, writes ignored.
// TESTING
//  JOBS=3, TMO=0, GO; flag model busy 40 cycles/job -> 3 kick writes of 8'h01, DONE=1, done_cnt=3.
//  JOBS=0, GO -> no master strobes, DONE=1 next cycle, BUSY never 1.
//  waitrequest held 5 cycles on kick and on poll -> strobes/data stable, exactly one transfer each.
//  TMO=100, flag stuck at 1 -> TMO=1, BUSY=0 within 100+POLL_GAP+2 cycles, DONE=0.
//  ABORT during second job's GAP (JOBS=4) -> IDLE, done_cnt=1, DONE=0; subsequent GO restarts at 0.
//  IRQ_EN build: IRQ_EN=1, JOBS=1 -> irq rises 1 cycle after DONE; w1c DONE -> irq 0 next cycle.

Source files
------------

// File: rtl/rsa_job_ctrl.sv
// rsa_job_ctrl
// ----------------------------------------------------------------------------
// Batch sequencer in front of the RSA Avalon engine. The host programs a job
// count and writes GO. For each job this block writes 8'h01 to the engine's
// flag slave and then polls the flag until bit0 (busy) reads 0. It reports
// progress, completion and timeout through a small register file.
//
// Optional feature macro: RSA_JOB_CTRL_IRQ_EN
//   defined   : CTRL[2] is IRQ_EN (rw), irq = registered IRQ_EN & (DONE | TMO)
//   undefined : irq tied 0, CTRL[2] reads 0 and ignores writes
//
// Host register map (word address):
//   0 CTRL  [0] GO (w1, self-clear)  [1] ABORT (w1, self-clear)  [2] IRQ_EN
//   1 JOBS  [CNT_W-1:0] jobs per batch (latched at GO)
//   2 STAT  [0] BUSY ro  [1] DONE w1c  [2] TMO w1c  [31:16] done_cnt ro
//   3 TMO   [TMO_W-1:0] per-job timeout in cycles, 0 disables (latched at GO)
//
// Ports:
//   clk, reset          clock, synchronous active-low reset
//   avs_h_*             host Avalon-MM slave, zero-latency reads, no stalls
//   avm_f_*             flag slave master port
//   irq                 level interrupt
//   dbg_state           current FSM state encoding, for observation only
//
// Master handshake: a request (avm_f_read or avm_f_write) is held with stable
// address/data while avm_f_waitrequest is 1. It is accepted in the cycle where
// the request is high and avm_f_waitrequest is 0; read data is valid in that
// same cycle. Read and write are never asserted together.
// ----------------------------------------------------------------------------
module rsa_job_ctrl #(
    parameter int CNT_W    = 16,
    parameter int TMO_W    = 24,
    parameter int POLL_GAP = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  avs_h_address,
    input  logic        avs_h_read,
    input  logic        avs_h_write,
    input  logic [31:0] avs_h_writedata,
    output logic [31:0] avs_h_readdata,
    output logic        avs_h_waitrequest,
    output logic        avm_f_address,
    output logic        avm_f_read,
    output logic        avm_f_write,
    output logic [7:0]  avm_f_writedata,
    input  logic [7:0]  avm_f_readdata,
    input  logic        avm_f_waitrequest,
    output logic        irq,
    output logic [2:0]  dbg_state
);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_KICK = 3'd1,
        ST_GAP  = 3'd2,
        ST_POLL = 3'd3,
        ST_NEXT = 3'd4
    } state_t;

    localparam int GAP_W = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;
    localparam logic [GAP_W-1:0] GAP_RELOAD = GAP_W'(POLL_GAP - 1);

    state_t             state, state_n;
    logic [GAP_W-1:0]   gap_cnt, gap_n;
    logic [TMO_W-1:0]   tmo_cnt, tmo_n;
    logic [CNT_W-1:0]   done_cnt, done_cnt_n;
    logic [CNT_W-1:0]   done_inc;
    logic [CNT_W-1:0]   jobs_reg, jobs_lat;
    logic [TMO_W-1:0]   tmo_reg, tmo_lat;
    logic               done_flag, tmo_flag;
    logic               done_set, tmo_set;
    logic               abort_req;
    logic               irq_en_bit;

    logic wr_ctrl, wr_jobs, wr_stat, wr_tmo;
    logic go, abort_now, idle, start, empty_go, abort, tmo_hit;

    assign wr_ctrl   = avs_h_write && (avs_h_address == 2'd0);
    assign wr_jobs   = avs_h_write && (avs_h_address == 2'd1);
    assign wr_stat   = avs_h_write && (avs_h_address == 2'd2);
    assign wr_tmo    = avs_h_write && (avs_h_address == 2'd3);
    assign go        = wr_ctrl && avs_h_writedata[0];
    assign abort_now = wr_ctrl && avs_h_writedata[1];

    assign idle      = (state == ST_IDLE);
    assign start     = go && idle && (jobs_reg != '0);
    assign empty_go  = go && idle && (jobs_reg == '0);
    // An abort written this cycle acts immediately; one written while a
    // transfer is stalled is remembered until the FSM reaches IDLE.
    assign abort     = (abort_req || abort_now) && !idle;
    assign tmo_hit   = (tmo_lat != '0) && (tmo_cnt >= tmo_lat);
    assign done_inc  = done_cnt + 1'b1;

    always_comb begin
        state_n         = state;
        gap_n           = gap_cnt;
        tmo_n           = tmo_cnt;
        done_cnt_n      = done_cnt;
        done_set        = 1'b0;
        tmo_set         = 1'b0;
        avm_f_read      = 1'b0;
        avm_f_write     = 1'b0;
        avm_f_writedata = 8'h00;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_n    = ST_KICK;
                    done_cnt_n = '0;
                    tmo_n      = '0;
                end else if (empty_go) begin
                    done_set   = 1'b1;
                    done_cnt_n = '0;
                end
            end
            ST_KICK: begin
                avm_f_write     = 1'b1;
                avm_f_writedata = 8'h01;
                if (!avm_f_waitrequest) begin
                    tmo_n   = '0;
                    gap_n   = GAP_RELOAD;
                    state_n = abort ? ST_IDLE : ST_GAP;
                end
            end
            ST_GAP: begin
                // Counter stops once the limit is reached so it cannot wrap.
                if (!tmo_hit) tmo_n = tmo_cnt + 1'b1;
                if (abort) begin
                    state_n = ST_IDLE;
                end else if (tmo_hit) begin
                    tmo_set = 1'b1;
                    state_n = ST_IDLE;
                end else if (gap_cnt == '0) begin
                    state_n = ST_POLL;
                end else begin
                    gap_n = gap_cnt - 1'b1;
                end
            end
            ST_POLL: begin
                avm_f_read = 1'b1;
                if (!tmo_hit) tmo_n = tmo_cnt + 1'b1;
                // Abort and timeout are only honoured once the read is accepted.
                if (!avm_f_waitrequest) begin
                    if (abort) begin
                        state_n = ST_IDLE;
                    end else if (!avm_f_readdata[0]) begin
                        state_n = ST_NEXT;
                    end else if (tmo_hit) begin
                        tmo_set = 1'b1;
                        state_n = ST_IDLE;
                    end else begin
                        gap_n   = GAP_RELOAD;
                        state_n = ST_GAP;
                    end
                end
            end
            ST_NEXT: begin
                done_cnt_n = done_inc;
                if (abort) begin
                    state_n = ST_IDLE;
                end else if (done_inc == jobs_lat) begin
                    done_set = 1'b1;
                    state_n  = ST_IDLE;
                end else begin
                    state_n = ST_KICK;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= ST_IDLE;
            gap_cnt   <= '0;
            tmo_cnt   <= '0;
            done_cnt  <= '0;
            jobs_reg  <= '0;
            jobs_lat  <= '0;
            tmo_reg   <= '0;
            tmo_lat   <= '0;
            done_flag <= 1'b0;
            tmo_flag  <= 1'b0;
            abort_req <= 1'b0;
        end else begin
            state    <= state_n;
            gap_cnt  <= gap_n;
            tmo_cnt  <= tmo_n;
            done_cnt <= done_cnt_n;
            if (start) begin
                jobs_lat <= jobs_reg;
                tmo_lat  <= tmo_reg;
            end
            if (wr_jobs) jobs_reg <= avs_h_writedata[CNT_W-1:0];
            if (wr_tmo)  tmo_reg  <= avs_h_writedata[TMO_W-1:0];
            // Hardware set beats a same-cycle host clear.
            done_flag <= done_set | (done_flag & ~(wr_stat & avs_h_writedata[1]));
            tmo_flag  <= tmo_set  | (tmo_flag  & ~(wr_stat & avs_h_writedata[2]));
            if (state_n == ST_IDLE) abort_req <= 1'b0;
            else if (abort_now && !idle) abort_req <= 1'b1;
        end
    end

`ifdef RSA_JOB_CTRL_IRQ_EN
    logic irq_en_q, irq_q;
    always_ff @(posedge clk) begin
        if (!reset) begin
            irq_en_q <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            if (wr_ctrl) irq_en_q <= avs_h_writedata[2];
            irq_q <= irq_en_q & (done_flag | tmo_flag);
        end
    end
    assign irq_en_bit = irq_en_q;
    assign irq        = irq_q;
`else
    assign irq_en_bit = 1'b0;
    assign irq        = 1'b0;
`endif

    always_comb begin
        avs_h_readdata = 32'h0;
        case (avs_h_address)
            2'd0: avs_h_readdata = {29'h0, irq_en_bit, 2'b00};
            2'd1: avs_h_readdata = 32'(jobs_reg);
            2'd2: avs_h_readdata = {16'(done_cnt), 13'h0, tmo_flag, done_flag, !idle};
            2'd3: avs_h_readdata = 32'(tmo_reg);
            default: avs_h_readdata = 32'h0;
        endcase
    end

    assign avs_h_waitrequest = 1'b0;
    assign avm_f_address     = 1'b0;
    assign dbg_state         = state;

    // Reads have no side effects and only bit0 of the flag matters.
    logic unused_ok;
    assign unused_ok = ^{avs_h_read, avs_h_writedata, avm_f_readdata[7:1]};

endmodule

// File: tb/tb_rsa_job_ctrl.sv
module tb_rsa_job_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  avs_h_address;
  logic        avs_h_read;
  logic        avs_h_write;
  logic [31:0] avs_h_writedata;
  logic [31:0] avs_h_readdata;
  logic        avs_h_waitrequest;
  logic        avm_f_address;
  logic        avm_f_read;
  logic        avm_f_write;
  logic [7:0]  avm_f_writedata;
  logic [7:0]  avm_f_readdata;
  logic        avm_f_waitrequest;
  logic        irq;
  logic [2:0]  dbg_state;

  rsa_job_ctrl #(.CNT_W(16), .TMO_W(24), .POLL_GAP(16)) dut (
    .clk               (clk),
    .reset             (reset_n),
    .avs_h_address     (avs_h_address),
    .avs_h_read        (avs_h_read),
    .avs_h_write       (avs_h_write),
    .avs_h_writedata   (avs_h_writedata),
    .avs_h_readdata    (avs_h_readdata),
    .avs_h_waitrequest (avs_h_waitrequest),
    .avm_f_address     (avm_f_address),
    .avm_f_read        (avm_f_read),
    .avm_f_write       (avm_f_write),
    .avm_f_writedata   (avm_f_writedata),
    .avm_f_readdata    (avm_f_readdata),
    .avm_f_waitrequest (avm_f_waitrequest),
    .irq               (irq),
    .dbg_state         (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // expected queues
  logic [7:0]  kick_q[$];
  logic [31:0] rd_q[$];
  string       rd_name_q[$];

  // flag slave model configuration and statistics
  int   busy_cyc   = 0;
  bit   stuck      = 0;
  int   stall_cfg  = 0;
  int   stall_left = 0;
  int   busy_left  = 0;
  int   kick_cnt   = 0;
  int   poll_cnt   = 0;
  int   strobe_cycles = 0;
  int   nonidle_cycles = 0;
  bit   prev_stall = 0;
  logic prev_w, prev_r;
  logic [7:0] prev_wd;

  // ---------------- driver tasks ----------------
  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic hw(input logic [1:0] a, input logic [31:0] d);
    avs_h_address   = a;
    avs_h_writedata = d;
    avs_h_write     = 1'b1;
    cyc(1);
    avs_h_write     = 1'b0;
  endtask

  task automatic hr(input string nm, input logic [1:0] a, input logic [31:0] exp);
    rd_q.push_back(exp);
    rd_name_q.push_back(nm);
    avs_h_address = a;
    avs_h_read    = 1'b1;
    cyc(1);
    avs_h_read    = 1'b0;
  endtask

  task automatic wait_idle(input string nm, input int budget, output int cycles);
    cycles = 0;
    do begin
      cyc(1);
      cycles++;
    end while (dbg_state != 3'd0 && cycles < budget);
    if (dbg_state != 3'd0) begin
      total++;
      bad++;
      $display("FAIL %s: still busy after %0d cycles, required idle", nm, cycles);
    end
  endtask

  task automatic push_kicks(input int n);
    for (int i = 0; i < n; i++) kick_q.push_back(8'h01);
  endtask

  // ---------------- flag slave model + master monitor ----------------
  always @(negedge clk) begin
    if (!reset_n) begin
      avm_f_waitrequest = 1'b0;
      avm_f_readdata    = 8'h00;
      prev_stall        = 0;
    end else begin
      if (prev_stall) begin
        total++;
        if (avm_f_write !== prev_w || avm_f_read !== prev_r || avm_f_writedata !== prev_wd) begin
          bad++;
          $display("FAIL stall_stable: got w=%b r=%b d=%h required w=%b r=%b d=%h",
                   avm_f_write, avm_f_read, avm_f_writedata, prev_w, prev_r, prev_wd);
        end
      end
      if (avm_f_read && avm_f_write) begin
        total++; bad++;
        $display("FAIL rw_exclusive: got read=1 write=1 required not both");
      end
      if (avm_f_address !== 1'b0) begin
        total++; bad++;
        $display("FAIL f_address: got %b required 0", avm_f_address);
      end
      if (dbg_state != 3'd0) nonidle_cycles++;
      if (busy_left > 0) busy_left--;
      if (avm_f_write || avm_f_read) begin
        strobe_cycles++;
        if (stall_left > 0) begin
          avm_f_waitrequest = 1'b1;
          stall_left--;
          prev_stall = 1;
          prev_w  = avm_f_write;
          prev_r  = avm_f_read;
          prev_wd = avm_f_writedata;
        end else begin
          avm_f_waitrequest = 1'b0;
          prev_stall = 0;
          stall_left = stall_cfg;
          if (avm_f_write) begin
            kick_cnt++;
            total++;
            if (kick_q.size() == 0) begin
              bad++;
              $display("FAIL kick_extra: got write %h required no transfer", avm_f_writedata);
            end else begin
              logic [7:0] e;
              e = kick_q.pop_front();
              if (avm_f_writedata !== e) begin
                bad++;
                $display("FAIL kick_data: got %h required %h", avm_f_writedata, e);
              end
            end
            busy_left = busy_cyc;
          end else begin
            poll_cnt++;
            avm_f_readdata = {7'h0, (stuck || busy_left != 0)};
          end
        end
      end else begin
        avm_f_waitrequest = 1'b0;
        prev_stall = 0;
      end
    end
  end

  // ---------------- host read monitor ----------------
  always @(negedge clk) begin
    if (reset_n && avs_h_read) begin
      total++;
      if (rd_q.size() == 0) begin
        bad++;
        $display("FAIL rd_unexpected: got %h required no read", avs_h_readdata);
      end else begin
        logic [31:0] e;
        string nm;
        e  = rd_q.pop_front();
        nm = rd_name_q.pop_front();
        if (avs_h_readdata !== e) begin
          bad++;
          $display("FAIL rd_%s: got %h expected %h", nm, avs_h_readdata, e);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int k0, p0, n0, s0, cycles;
    reset_n         = 1'b0;
    avs_h_address   = 2'd0;
    avs_h_read      = 1'b0;
    avs_h_write     = 1'b0;
    avs_h_writedata = 32'h0;
    cyc(4);
    reset_n = 1'b1;
    cyc(1);

    // reset values
    chk("reset_state", 32'(dbg_state), 32'd0);
    chk("reset_irq", 32'(irq), 32'd0);
    hr("reset_ctrl", 2'd0, 32'h0);
    hr("reset_jobs", 2'd1, 32'h0);
    hr("reset_stat", 2'd2, 32'h0);
    hr("reset_tmo",  2'd3, 32'h0);

    // three jobs, flag busy 40 cycles each
    busy_cyc = 40;
    hw(2'd1, 32'd3);
    hr("jobs3", 2'd1, 32'd3);
    k0 = kick_cnt;
    push_kicks(3);
    hw(2'd0, 32'h1);
    hr("stat_busy", 2'd2, 32'h0000_0001);
    wait_idle("batch3", 2000, cycles);
    hr("stat_done3", 2'd2, 32'h0003_0002);
    chk("kicks3", 32'(kick_cnt - k0), 32'd3);

    // w1c DONE, then GO with zero jobs
    hw(2'd2, 32'h2);
    hr("stat_cleared", 2'd2, 32'h0003_0000);
    hw(2'd1, 32'd0);
    k0 = kick_cnt; p0 = poll_cnt; n0 = nonidle_cycles;
    hw(2'd0, 32'h1);
    hr("stat_empty_go", 2'd2, 32'h0000_0002);
    cyc(5);
    chk("empty_kicks", 32'(kick_cnt - k0), 32'd0);
    chk("empty_polls", 32'(poll_cnt - p0), 32'd0);
    chk("empty_busy_cycles", 32'(nonidle_cycles - n0), 32'd0);

    // five-cycle waitrequest on kick and poll
    hw(2'd2, 32'h2);
    stall_cfg = 5; stall_left = 5; busy_cyc = 0;
    hw(2'd1, 32'd1);
    k0 = kick_cnt; p0 = poll_cnt; s0 = strobe_cycles;
    push_kicks(1);
    hw(2'd0, 32'h1);
    wait_idle("stall_job", 500, cycles);
    chk("stall_kicks", 32'(kick_cnt - k0), 32'd1);
    chk("stall_polls", 32'(poll_cnt - p0), 32'd1);
    chk("stall_strobe_cycles", 32'(strobe_cycles - s0), 32'd12);
    hr("stat_stall", 2'd2, 32'h0001_0002);
    stall_cfg = 0; stall_left = 0;

    // timeout with flag stuck busy
    hw(2'd2, 32'h2);
    hw(2'd3, 32'd100);
    hr("tmo100", 2'd3, 32'd100);
    stuck = 1;
    hw(2'd1, 32'd2);
    push_kicks(1);
    hw(2'd0, 32'h1);
    wait_idle("tmo_job", 500, cycles);
    chk("tmo_within_limit", 32'(cycles <= 118), 32'd1);
    hr("stat_tmo", 2'd2, 32'h0000_0004);
    stuck = 0;
    hw(2'd2, 32'h4);
    hr("stat_tmo_clr", 2'd2, 32'h0);
    hw(2'd3, 32'd0);

    // abort in second job's gap
    busy_cyc = 40;
    hw(2'd1, 32'd4);
    k0 = kick_cnt;
    push_kicks(2);
    hw(2'd0, 32'h1);
    cycles = 0;
    while (kick_cnt - k0 < 2 && cycles < 400) begin
      cyc(1);
      cycles++;
    end
    chk("abort_second_kick_seen", 32'(kick_cnt - k0), 32'd2);
    cyc(3);
    hw(2'd0, 32'h2);
    wait_idle("abort", 50, cycles);
    hr("stat_abort", 2'd2, 32'h0001_0000);
    chk("abort_kicks", 32'(kick_cnt - k0), 32'd2);
    // restart from zero
    busy_cyc = 2;
    push_kicks(4);
    hw(2'd0, 32'h1);
    hr("stat_restart", 2'd2, 32'h0000_0001);
    wait_idle("restart", 2000, cycles);
    hr("stat_restart_done", 2'd2, 32'h0004_0002);

    // interrupt
    hw(2'd2, 32'h2);
    hw(2'd0, 32'h4);
    hw(2'd1, 32'd1);
    push_kicks(1);
`ifdef RSA_JOB_CTRL_IRQ_EN
    hr("ctrl_irq_en", 2'd0, 32'h4);
    hw(2'd0, 32'h5);
    avs_h_address = 2'd2;
    cycles = 0;
    while (avs_h_readdata[1] !== 1'b1 && cycles < 500) begin
      cyc(1);
      cycles++;
    end
    chk("irq_done_seen", 32'(avs_h_readdata[1]), 32'd1);
    chk("irq_lag_low", 32'(irq), 32'd0);
    cyc(1);
    chk("irq_high", 32'(irq), 32'd1);
    hw(2'd2, 32'h2);
    cyc(1);
    chk("irq_cleared", 32'(irq), 32'd0);
`else
    hr("ctrl_irq_en_off", 2'd0, 32'h0);
    hw(2'd0, 32'h5);
    wait_idle("irq_job", 500, cycles);
    cyc(2);
    chk("irq_tied_low", 32'(irq), 32'd0);
`endif

    cyc(2);
    chk("kick_q_empty", 32'(kick_q.size()), 32'd0);
    chk("rd_q_empty", 32'(rd_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
